rv32i_multicycle_controller: RTL and testbench
==============================================

# rv32i_multicycle_controller

Moore-style control FSM that sequences the shared datapath of the RV32I multicycle core: one ALU, one memory port, the register file, and the non-architectural registers (IR, PC_old, A/B, alu_last, mem_data). It decodes the registered instruction fields and drives every write enable and mux select the core needs. It also counts retired instructions and parks in an error state on illegal opcodes or memory exceptions. It instantiates inside the core and replaces the core's inline state logic.

## Interface

Parameters:
- none

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset asserted)
- ena  in  1  global advance enable
- op  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7  in  7  IR[31:25]
- zero  in  1  ALU zero flag
- equal  in  1  ALU equal flag
- mem_exception  in  mem_exception_mask_t  memory fault mask; any bit set means fault
- PC_ena, PC_old_ena, IR_write, reg_write, mem_wr_ena, ALU_ena, mem_data_ena  out  1 each  register/memory write enables
- mem_src  out  mem_src_t  MEM_SRC_PC / MEM_SRC_RESULT
- result_src  out  result_src_t  RESULT_SRC_ALU / _MEM_DATA / _ALU_LAST
- alu_src_a  out  alu_src_a_t  SRC_A_PC / SRC_A_PC_OLD / SRC_A_REG_A / SRC_A_ZERO
- alu_src_b  out  alu_src_b_t  SRC_B_REG_B / SRC_B_IMM / SRC_B_4
- alu_control  out  alu_control_t  ALU operation
- instruction_done  out  1  one-cycle retire pulse
- instructions_completed  out  32  retired count
- halted  out  1  high in S_ERROR
- state  out  ctrl_state_t  current state, for debug

## Operation

- **States:** S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_ERROR.
- **S_FETCH:**
  - mem_src=PC, IR_write=1, PC_old_ena=1.
  - ALU computes PC+4 (SRC_A_PC, SRC_B_4, ALU_ADD); result goes to PC, PC_ena=1.
  - Next state is S_DECODE.
- **S_DECODE:**
  - ALU computes PC_old+imm with ALU_ENA=1, giving the branch/JAL target in alu_last.
  - Dispatch on op:
    - 0x03 or 0x23 → S_MEMADR
    - 0x33 → S_EXECUTER
    - 0x13 → S_EXECUTEI
    - 0x63 → S_BRANCH
    - 0x6F → S_JAL
    - 0x67 → S_JALR
    - 0x37 → S_LUI
    - otherwise → S_ERROR
- **S_MEMADR:** computes A+imm with ADD, ALU_ena=1. Next state is S_MEMREAD for a load, S_MEMWRITE for a store.
- **S_MEMREAD:** mem_src=RESULT, mem_data_ena=1. Next state is S_MEMWB.
- **S_MEMWB:** result_src=MEM_DATA, reg_write=1, retire.
- **S_MEMWRITE:** mem_src=RESULT, mem_wr_ena=1, retire.
- **S_EXECUTER / S_EXECUTEI:**
  - Sources are A,B (R-type) or A,imm (I-type); ALU_ena=1; next state is S_ALUWB.
  - alu_control comes from the alu_decoder.
  - SUB/SRA are selected by funct7[5]. funct7[5] is honoured for I-type only when funct3=101.
- **S_ALUWB:** result_src=ALU_LAST, reg_write=1, retire.
- **S_BRANCH:**
  - Compare A,B using SUB for BEQ/BNE, SLT for BLT/BGE, SLTU for BLTU/BGEU.
  - Taken is: equal for BEQ, !equal for BNE, !zero for BLT/BLTU, zero for BGE/BGEU.
  - If taken: PC_next=alu_last, PC_ena=1. Retire either way.
  - funct3 010 or 011 → S_ERROR.
- **S_JAL:**
  - Writes PC (already PC_old+4) to rd via SRC_A_PC+SRC_B_4−4… simplified: result_src=ALU, ALU computes PC_old+4, reg_write=1.
  - In the same cycle PC_next=alu_last, PC_ena=1. Retire.
- **S_JALR:** computes A+imm with ALU_ena=1, then goes to S_JAL-like writeback with PC_next=ALU_LAST & ~1. Two states are permitted; the spec fixes the total cycle count only.
- **S_LUI:** computes ZERO+imm with ALU_ena=1. Next state is S_ALUWB.
- **Retire:** the state's final cycle asserts instruction_done, increments instructions_completed (32-bit, wraps at 2^32−1 → 0), and returns to S_FETCH.
- **S_ERROR:** terminal until reset. halted=1; all enables 0; counter frozen.

## Timing

- **CPI:** load 5; store 4; R-type/I-type/LUI 4; branch 3; JAL 3; JALR 4.
- **Reset:**
  - While rst=0: state=S_FETCH, instructions_completed=0, halted=0, and all write enables are forced 0.
  - On the first edge after rst rises, the FETCH enables take effect.
- **ena=0:** state and counter hold; every write enable and instruction_done is forced 0; mux selects still follow state. Resuming with ena=1 continues the same state with no lost or duplicated work.
- **Memory faults:** mem_exception≠0 in any cycle with a memory access (FETCH, MEMREAD, MEMWRITE) and ena=1 causes:
  - that cycle's enables are suppressed;
  - the next state is S_ERROR;
  - no retire.
- **Precedence:** rst > mem_exception > ena > normal dispatch.
- **Flag-dependent outputs:** only PC_ena in S_BRANCH depends on zero/equal, and it is combinational from the current cycle's flags.

## Structure

- Shared package (rv32_common): ctrl_state_t, mem_src_t, result_src_t, alu_src_a_t, alu_src_b_t, and opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI).
- Sub-module: alu_decoder, combinational, mapping {op, funct3, funct7} to alu_control_t.

## Test plan

- **addi:** IR=0x00500093 (addi x1,x0,5) → states FETCH, DECODE, EXECUTEI, ALUWB. instruction_done is high in cycle 4 only; count=1; reg_write=1 in ALUWB only.
- **lw:** lw x2,0(x1) → 5 states ending in MEMWB with result_src=MEM_DATA; mem_src=RESULT in MEMREAD.
- **beq:** beq with equal=1 → PC_ena=1 in BRANCH, 3 cycles. With equal=0 → PC_ena=0 in BRANCH, still retires.
- **ena stall:** ena=0 for 3 cycles during S_MEMADR → state held, no enables, instruction_done never asserts. Store completes 4 active cycles after start.
- **Faults:** op=0x7F in DECODE → S_ERROR, halted=1, count frozen. mem_exception=1 in FETCH → S_ERROR with IR_write=0.
- **Reset and wrap:**
  - rst pulsed low mid-load → immediate S_FETCH, count=0.
  - With the counter forced to 0xFFFFFFFF, one retire → 0.

Source files
------------

// File: rtl/rv32_common.sv
// Shared types and opcode constants for the RV32I multicycle core and its
// control FSM.
package rv32_common;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_LUI,
        S_ERROR
    } ctrl_state_t;

    typedef enum logic {
        MEM_SRC_PC,
        MEM_SRC_RESULT
    } mem_src_t;

    typedef enum logic [1:0] {
        RESULT_SRC_ALU,
        RESULT_SRC_MEM_DATA,
        RESULT_SRC_ALU_LAST
    } result_src_t;

    typedef enum logic [1:0] {
        SRC_A_PC,
        SRC_A_PC_OLD,
        SRC_A_REG_A,
        SRC_A_ZERO
    } alu_src_a_t;

    typedef enum logic [1:0] {
        SRC_B_REG_B,
        SRC_B_IMM,
        SRC_B_4
    } alu_src_b_t;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLT,
        ALU_SLTU,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA
    } alu_control_t;

    // Any set bit is a fault on the access in progress.
    typedef struct packed {
        logic misaligned;
        logic access_fault;
    } mem_exception_mask_t;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_RTYPE  = 7'h33;
    localparam logic [6:0] OP_ITYPE  = 7'h13;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_LUI    = 7'h37;

endpackage

// File: rtl/alu_decoder.sv
// Maps the registered instruction fields to the ALU operation used in the
// execute and branch-compare states.
module alu_decoder
    import rv32_common::*;
(
    input  logic [6:0]   op,
    input  logic [2:0]   funct3,
    input  logic [6:0]   funct7,
    output alu_control_t alu_control
);

    logic unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    always_comb begin
        alu_control = ALU_ADD;
        if (op == OP_BRANCH) begin
            case (funct3[2:1])
                2'b10:   alu_control = ALU_SLT;
                2'b11:   alu_control = ALU_SLTU;
                default: alu_control = ALU_SUB;
            endcase
        end else if (op == OP_RTYPE || op == OP_ITYPE) begin
            case (funct3)
                // I-type funct7 bits are immediate bits here, so only R-type may SUB.
                3'b000:  alu_control = (op == OP_RTYPE && funct7[5]) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_control = ALU_SLL;
                3'b010:  alu_control = ALU_SLT;
                3'b011:  alu_control = ALU_SLTU;
                3'b100:  alu_control = ALU_XOR;
                3'b101:  alu_control = funct7[5] ? ALU_SRA : ALU_SRL;
                3'b110:  alu_control = ALU_OR;
                default: alu_control = ALU_AND;
            endcase
        end
    end

endmodule

// File: rtl/rv32i_multicycle_controller.sv
// Moore control FSM for the RV32I multicycle core: sequences the shared ALU,
// memory port and register file, counts retired instructions, halts on faults.
module rv32i_multicycle_controller
    import rv32_common::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic [6:0]          op,
    input  logic [2:0]          funct3,
    input  logic [6:0]          funct7,
    input  logic                zero,
    input  logic                equal,
    input  mem_exception_mask_t mem_exception,
    output logic                PC_ena,
    output logic                PC_old_ena,
    output logic                IR_write,
    output logic                reg_write,
    output logic                mem_wr_ena,
    output logic                ALU_ena,
    output logic                mem_data_ena,
    output mem_src_t            mem_src,
    output result_src_t         result_src,
    output alu_src_a_t          alu_src_a,
    output alu_src_b_t          alu_src_b,
    output alu_control_t        alu_control,
    output logic                instruction_done,
    output logic [31:0]         instructions_completed,
    output logic                halted,
    output ctrl_state_t         state
);

    ctrl_state_t  state_q;
    logic [31:0]  retired_count;
    alu_control_t dec_alu;
    logic         mem_access, fault, active, taken, bad_branch;
    logic         pc_c, pc_old_c, ir_c, rw_c, mw_c, alu_c, md_c, retire_c;

    alu_decoder u_alu_decoder (
        .op          (op),
        .funct3      (funct3),
        .funct7      (funct7),
        .alu_control (dec_alu)
    );

    assign mem_access = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
    assign fault      = |mem_exception;
    // Enables only fire when out of reset, advancing, and not faulting this cycle.
    assign active     = rst && ena && !(mem_access && fault);
    assign bad_branch = (funct3[2:1] == 2'b01);

    always_comb begin
        case (funct3)
            3'b000:          taken = equal;
            3'b001:          taken = !equal;
            3'b100, 3'b110:  taken = !zero;
            3'b101, 3'b111:  taken = zero;
            default:         taken = 1'b0;
        endcase
    end

    always_comb begin
        {pc_c, pc_old_c, ir_c, rw_c, mw_c, alu_c, md_c, retire_c} = '0;
        mem_src     = MEM_SRC_PC;
        result_src  = RESULT_SRC_ALU_LAST;
        alu_src_a   = SRC_A_PC;
        alu_src_b   = SRC_B_4;
        alu_control = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                ir_c = 1'b1; pc_old_c = 1'b1; pc_c = 1'b1;
                result_src = RESULT_SRC_ALU;
            end
            S_DECODE: begin
                alu_src_a = SRC_A_PC_OLD; alu_src_b = SRC_B_IMM; alu_c = 1'b1;
            end
            S_MEMADR, S_JALR: begin
                alu_src_a = SRC_A_REG_A; alu_src_b = SRC_B_IMM; alu_c = 1'b1;
            end
            S_MEMREAD: begin
                mem_src = MEM_SRC_RESULT; md_c = 1'b1;
            end
            S_MEMWB: begin
                result_src = RESULT_SRC_MEM_DATA; rw_c = 1'b1; retire_c = 1'b1;
            end
            S_MEMWRITE: begin
                mem_src = MEM_SRC_RESULT; mw_c = 1'b1; retire_c = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a = SRC_A_REG_A; alu_src_b = SRC_B_REG_B; alu_c = 1'b1;
                alu_control = dec_alu;
            end
            S_EXECUTEI: begin
                alu_src_a = SRC_A_REG_A; alu_src_b = SRC_B_IMM; alu_c = 1'b1;
                alu_control = dec_alu;
            end
            S_ALUWB: begin
                rw_c = 1'b1; retire_c = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = SRC_A_REG_A; alu_src_b = SRC_B_REG_B;
                alu_control = dec_alu;
                pc_c = taken && !bad_branch; retire_c = !bad_branch;
            end
            S_JAL: begin
                alu_src_a = SRC_A_PC_OLD; alu_src_b = SRC_B_4; result_src = RESULT_SRC_ALU;
                rw_c = 1'b1; pc_c = 1'b1; retire_c = 1'b1;
            end
            S_LUI: begin
                alu_src_a = SRC_A_ZERO; alu_src_b = SRC_B_IMM; alu_c = 1'b1;
            end
            default: ;
        endcase
    end

    assign PC_ena                 = pc_c && active;
    assign PC_old_ena             = pc_old_c && active;
    assign IR_write               = ir_c && active;
    assign reg_write              = rw_c && active;
    assign mem_wr_ena             = mw_c && active;
    assign ALU_ena                = alu_c && active;
    assign mem_data_ena           = md_c && active;
    assign instruction_done       = retire_c && active;
    assign instructions_completed = retired_count;
    assign halted                 = (state_q == S_ERROR);
    assign state                  = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_FETCH;
            retired_count <= '0;
        end else if (ena) begin
            if (instruction_done) retired_count <= retired_count + 32'd1;
            if (mem_access && fault) begin
                state_q <= S_ERROR;
            end else begin
                case (state_q)
                    S_FETCH: state_q <= S_DECODE;
                    S_DECODE: begin
                        case (op)
                            OP_LOAD, OP_STORE: state_q <= S_MEMADR;
                            OP_RTYPE:          state_q <= S_EXECUTER;
                            OP_ITYPE:          state_q <= S_EXECUTEI;
                            OP_BRANCH:         state_q <= S_BRANCH;
                            OP_JAL:            state_q <= S_JAL;
                            OP_JALR:           state_q <= S_JALR;
                            OP_LUI:            state_q <= S_LUI;
                            default:           state_q <= S_ERROR;
                        endcase
                    end
                    S_MEMADR:   state_q <= (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
                    S_MEMREAD:  state_q <= S_MEMWB;
                    S_EXECUTER, S_EXECUTEI, S_LUI: state_q <= S_ALUWB;
                    S_BRANCH:   state_q <= bad_branch ? S_ERROR : S_FETCH;
                    // JALR's target is in alu_last; the JAL writeback finishes it.
                    S_JALR:     state_q <= S_JAL;
                    S_MEMWB, S_MEMWRITE, S_ALUWB, S_JAL: state_q <= S_FETCH;
                    default:    state_q <= S_ERROR;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rv32i_multicycle_controller.sv
// Bench for rv32i_multicycle_controller: per-cycle expected control vectors are
// queued as stimulus is driven and compared on the following falling edge.
module tb_rv32i_multicycle_controller;
    import rv32_common::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ena = 1'b0;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic [6:0] funct7 = '0;
    logic zero = 1'b0;
    logic equal = 1'b0;
    mem_exception_mask_t mem_exception = '0;

    logic PC_ena, PC_old_ena, IR_write, reg_write, mem_wr_ena, ALU_ena, mem_data_ena;
    mem_src_t mem_src;
    result_src_t result_src;
    alu_src_a_t alu_src_a;
    alu_src_b_t alu_src_b;
    alu_control_t alu_control;
    logic instruction_done, halted;
    logic [31:0] instructions_completed;
    ctrl_state_t state;

    rv32i_multicycle_controller dut (
        .clk(clk), .rst(rst), .ena(ena), .op(op), .funct3(funct3), .funct7(funct7),
        .zero(zero), .equal(equal), .mem_exception(mem_exception),
        .PC_ena(PC_ena), .PC_old_ena(PC_old_ena), .IR_write(IR_write),
        .reg_write(reg_write), .mem_wr_ena(mem_wr_ena), .ALU_ena(ALU_ena),
        .mem_data_ena(mem_data_ena), .mem_src(mem_src), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
        .instruction_done(instruction_done), .instructions_completed(instructions_completed),
        .halted(halted), .state(state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [55:0] exp_q[$];
    logic [31:0] exp_count = '0;

    task automatic check(input string tag, input logic [55:0] obs, input logic [55:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Bit order: {PC_ena, PC_old_ena, IR_write, reg_write, mem_wr_ena, ALU_ena, mem_data_ena}
    function automatic logic [17:0] nominal(input ctrl_state_t st, input alu_control_t ac);
        logic [6:0] en;
        mem_src_t ms;
        result_src_t rs;
        alu_src_a_t sa;
        alu_src_b_t sb;
        alu_control_t a;
        en = '0; ms = MEM_SRC_PC; rs = RESULT_SRC_ALU_LAST; sa = SRC_A_PC; sb = SRC_B_4; a = ALU_ADD;
        case (st)
            S_FETCH:    begin en = 7'b1110000; rs = RESULT_SRC_ALU; end
            S_DECODE:   begin en = 7'b0000010; sa = SRC_A_PC_OLD; sb = SRC_B_IMM; end
            S_MEMADR:   begin en = 7'b0000010; sa = SRC_A_REG_A; sb = SRC_B_IMM; end
            S_JALR:     begin en = 7'b0000010; sa = SRC_A_REG_A; sb = SRC_B_IMM; end
            S_MEMREAD:  begin en = 7'b0000001; ms = MEM_SRC_RESULT; end
            S_MEMWB:    begin en = 7'b0001000; rs = RESULT_SRC_MEM_DATA; end
            S_MEMWRITE: begin en = 7'b0000100; ms = MEM_SRC_RESULT; end
            S_EXECUTER: begin en = 7'b0000010; sa = SRC_A_REG_A; sb = SRC_B_REG_B; a = ac; end
            S_EXECUTEI: begin en = 7'b0000010; sa = SRC_A_REG_A; sb = SRC_B_IMM; a = ac; end
            S_ALUWB:    begin en = 7'b0001000; end
            S_BRANCH:   begin sa = SRC_A_REG_A; sb = SRC_B_REG_B; a = ac; end
            S_JAL:      begin en = 7'b1001000; sa = SRC_A_PC_OLD; rs = RESULT_SRC_ALU; end
            S_LUI:      begin en = 7'b0000010; sa = SRC_A_ZERO; sb = SRC_B_IMM; end
            default: ;
        endcase
        return {en, ms, rs, sa, sb, a};
    endfunction

    // driver: one cycle of stimulus plus its expected outputs
    task automatic cyc(input ctrl_state_t st, input alu_control_t ac, input logic en_v,
                       input logic [1:0] exc, input logic taken, input logic done);
        logic [17:0] n;
        ena = en_v;
        mem_exception = exc;
        n = nominal(st, ac);
        if (st == S_BRANCH) n[17] = taken;
        if (!en_v || exc != 2'b00) n[17:11] = '0;
        exp_q.push_back({st, n, done, (st == S_ERROR), exp_count});
        if (done) exp_count = exp_count + 32'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ir(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
        op = o; funct3 = f3; funct7 = f7;
    endtask

    task automatic fd();
        cyc(S_FETCH, ALU_ADD, 1'b1, 2'b00, 1'b0, 1'b0);
        cyc(S_DECODE, ALU_ADD, 1'b1, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        ena = 1'b1;
        exp_count = '0;
        #1;
        check(tag, {16'h0, state, PC_ena, PC_old_ena, IR_write, reg_write, mem_wr_ena, ALU_ena,
                    mem_data_ena, instruction_done, halted, instructions_completed},
              {16'h0, S_FETCH, 9'b0, 32'h0});
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // scoreboard: pop one expected vector per active comparison cycle
    always @(negedge clk) begin
        logic [55:0] e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("cyc", {state, PC_ena, PC_old_ena, IR_write, reg_write, mem_wr_ena, ALU_ena,
                          mem_data_ena, mem_src, result_src, alu_src_a, alu_src_b, alu_control,
                          instruction_done, halted, instructions_completed}, e);
        end
    end

    initial begin
        do_reset("rst_init");

        // addi x1,x0,5
        set_ir(7'h13, 3'b000, 7'h00);
        fd();
        cyc(S_EXECUTEI, ALU_ADD, 1'b1, 2'b00, 1'b0, 1'b0);
        cyc(S_ALUWB, ALU_ADD, 1'b1, 2'b00, 1'b0, 1'b1);

        // lw x2,0(x1)
        set_ir(7'h03, 3'b010, 7'h00);
        fd();
        cyc(S_MEMADR, ALU_ADD, 1'b1, 2'b00, 1'b0, 1'b0);
        cyc(S_MEMREAD, ALU_ADD, 1'b1, 2'b00, 1'b0, 1'b0);
        cyc(S_MEMWB, ALU_ADD, 1'b1, 2'b00, 1'b0, 1'b1);

        // beq taken / not taken
        set_ir(7'h63, 3'b000, 7'h00);
        equal = 1'b1;
        fd();
        cyc(S_BRANCH, ALU_SUB, 1'b1, 2'b00, 1'b1, 1'b1);
        equal = 1'b0;
        fd();
        cyc(S_BRANCH, ALU_SUB, 1'b1, 2'b00, 1'b0, 1'b1);
        // bne with equal=0 taken, blt with zero=0 taken, bgeu with zero=1 taken, bltu zero=1 not
        set_ir(7'h63, 3'b001, 7'h00);
        fd();
        cyc(S_BRANCH, ALU_SUB, 1'b1, 2'b00, 1'b1, 1'b1);
        set_ir(7'h63, 3'b100, 7'h00);
        zero = 1'b0;
        fd();
        cyc(S_BRANCH, ALU_SLT, 1'b1, 2'b00, 1'b1, 1'b1);
        set_ir(7'h63, 3'b111, 7'h00);
        zero = 1'b1;
        fd();
        cyc(S_BRANCH, ALU_SLTU, 1'b1, 2'b00, 1'b1, 1'b1);
        set_ir(7'h63, 3'b110, 7'h00);
        fd();
        cyc(S_BRANCH, ALU_SLTU, 1'b1, 2'b00, 1'b0, 1'b1);

        // ALU decode: sub, srai, addi with imm[10] set, random R-type or
        set_ir(7'h33, 3'b000, 7'h20);
        fd();
        cyc(S_EXECUTER, ALU_SUB, 1'b1, 2'b00, 1'b0, 1'b0);
        cyc(S_ALUWB, ALU_ADD, 1'b1, 2'b00, 1'b0, 1'b1);
        set_ir(7'h13, 3'b101, 7'h20);
        fd();
        cyc(S_EXECUTEI, ALU_SRA, 1'b1, 2'b00, 1'b0, 1'b0);
        cyc(S_ALUWB, ALU_ADD, 1'b1, 2'b00, 1'b0, 1'b1);
        set_ir(7'h13, 3'b000, 7'h20);
        fd();
        cyc(S_EXECUTEI, ALU_ADD, 1'b1, 2'b00, 1'b0, 1'b0);
        cyc(S_ALUWB, ALU_ADD, 1'b1, 2'b00, 1'b0, 1'b1);
        set_ir(7'h33, 3'b110, 7'($urandom_range(0, 127)));
        fd();
        cyc(S_EXECUTER, ALU_OR, 1'b1, 2'b00, 1'b0, 1'b0);
        // stall in the writeback cycle: no retire until ena returns
        cyc(S_ALUWB, ALU_ADD, 1'b0, 2'b00, 1'b0, 1'b0);
        cyc(S_ALUWB, ALU_ADD, 1'b1, 2'b00, 1'b0, 1'b1);

        // jal, jalr, lui
        set_ir(7'h6F, 3'b000, 7'h00);
        fd();
        cyc(S_JAL, ALU_ADD, 1'b1, 2'b00, 1'b0, 1'b1);
        set_ir(7'h67, 3'b000, 7'h00);
        fd();
        cyc(S_JALR, ALU_ADD, 1'b1, 2'b00, 1'b0, 1'b0);
        cyc(S_JAL, ALU_ADD, 1'b1, 2'b00, 1'b0, 1'b1);
        set_ir(7'h37, 3'b000, 7'h00);
        fd();
        cyc(S_LUI, ALU_ADD, 1'b1, 2'b00, 1'b0, 1'b0);
        cyc(S_ALUWB, ALU_ADD, 1'b1, 2'b00, 1'b0, 1'b1);

        // store with a 3-cycle stall in MEMADR
        set_ir(7'h23, 3'b010, 7'h00);
        fd();
        for (int i = 0; i < 3; i++) cyc(S_MEMADR, ALU_ADD, 1'b0, 2'b00, 1'b0, 1'b0);
        cyc(S_MEMADR, ALU_ADD, 1'b1, 2'b00, 1'b0, 1'b0);
        cyc(S_MEMWRITE, ALU_ADD, 1'b1, 2'b00, 1'b0, 1'b1);

        // counter wrap
        set_ir(7'h13, 3'b000, 7'h00);
        fd();
        cyc(S_EXECUTEI, ALU_ADD, 1'b1, 2'b00, 1'b0, 1'b0);
        force dut.retired_count = 32'hFFFF_FFFF;
        #1;
        release dut.retired_count;
        exp_count = 32'hFFFF_FFFF;
        cyc(S_ALUWB, ALU_ADD, 1'b1, 2'b00, 1'b0, 1'b1);
        fd();

        // reset mid-load (DUT is in EXECUTEI now; restart cleanly first)
        do_reset("rst_mid0");
        set_ir(7'h03, 3'b010, 7'h00);
        fd();
        cyc(S_MEMADR, ALU_ADD, 1'b1, 2'b00, 1'b0, 1'b0);
        cyc(S_MEMREAD, ALU_ADD, 1'b1, 2'b00, 1'b0, 1'b0);
        do_reset("rst_midload");
        fd();
        cyc(S_MEMADR, ALU_ADD, 1'b1, 2'b00, 1'b0, 1'b0);
        cyc(S_MEMREAD, ALU_ADD, 1'b1, 2'b00, 1'b0, 1'b0);
        cyc(S_MEMWB, ALU_ADD, 1'b1, 2'b00, 1'b0, 1'b1);

        // illegal opcode: halts with the count frozen
        set_ir(7'h7F, 3'b000, 7'h00);
        fd();
        for (int i = 0; i < 3; i++) cyc(S_ERROR, ALU_ADD, 1'b1, 2'b00, 1'b0, 1'b0);

        // fetch fault
        do_reset("rst_fault0");
        set_ir(7'h13, 3'b000, 7'h00);
        cyc(S_FETCH, ALU_ADD, 1'b1, 2'b01, 1'b0, 1'b0);
        cyc(S_ERROR, ALU_ADD, 1'b1, 2'b00, 1'b0, 1'b0);
        cyc(S_ERROR, ALU_ADD, 1'b1, 2'b00, 1'b0, 1'b0);

        // load fault in MEMREAD
        do_reset("rst_fault1");
        set_ir(7'h03, 3'b010, 7'h00);
        fd();
        cyc(S_MEMADR, ALU_ADD, 1'b1, 2'b00, 1'b0, 1'b0);
        cyc(S_MEMREAD, ALU_ADD, 1'b1, 2'b10, 1'b0, 1'b0);
        cyc(S_ERROR, ALU_ADD, 1'b1, 2'b00, 1'b0, 1'b0);

        // illegal branch funct3: no retire, halts
        do_reset("rst_fault2");
        set_ir(7'h63, 3'b010, 7'h00);
        fd();
        cyc(S_BRANCH, ALU_SUB, 1'b1, 2'b00, 1'b0, 1'b0);
        cyc(S_ERROR, ALU_ADD, 1'b1, 2'b00, 1'b0, 1'b0);

        @(posedge clk);
        check("sb_drain", 56'(exp_q.size()), 56'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
